aes_round_scheduler: RTL and testbench
======================================

Name: aes_round_scheduler

Overview:
- Iterative AES sequencer. It owns the 128-bit cipher state register and time-multiplexes one external round datapath across all NR rounds, for encrypt or decrypt.
- Sits between the block-level valid/ready interface and the round datapath (forward or inverse round, final-round variant).
- Fetches round keys from an external expanded-key store by index.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- IDX_W, 4, width of the round-key index; must satisfy 2**IDX_W > NR.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; takes effect on the rising edge of clock.
- in_valid  input  1  new block offered.
- in_ready  output  1  scheduler can accept a block.
- in_inv  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
- in_data  input  128  plaintext (encrypt) or ciphertext (decrypt).
- rk_idx  output  IDX_W  round-key index requested this cycle.
- rk_data  input  128  round key for rk_idx, valid in the same cycle (combinational store).
- dp_in  output  128  current cipher state to the datapath.
- dp_key  output  128  equals rk_data.
- dp_inv  output  1  selects the inverse round.
- dp_final  output  1  selects the final-round variant (no MixColumns / InvMixColumns).
- dp_out  input  128  combinational datapath result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  128  result block.

Behaviour:
- FSM states: IDLE, ROUND, DONE. Internal registers: st[127:0], rnd (IDX_W bits), inv.
- Reset: FSM=IDLE, st=0, rnd=0, inv=0. Outputs after reset: in_ready=1, out_valid=0, out_data=0, dp_final=0, dp_inv=0, rk_idx=0.
- IDLE:
  - in_ready=1.
  - rk_idx = in_inv ? NR : 0.
  - On in_valid: st <= in_data ^ rk_data (initial AddRoundKey), inv <= in_inv, rnd <= 1, go to ROUND.
- ROUND:
  - in_ready=0. dp_in=st, dp_inv=inv.
  - rk_idx = inv ? NR-rnd : rnd.
  - dp_final = (rnd==NR).
  - Each cycle: st <= dp_out.
  - If rnd==NR, go to DONE; otherwise rnd <= rnd+1.
- DONE:
  - out_valid=1, out_data=st. in_ready=0.
  - Hold st and out_data stable while out_ready=0.
  - On out_ready: go to IDLE, rnd <= 0. A new block may be accepted on the following cycle, not the same one.
- Latency: accept on cycle T, out_valid first high on cycle T+NR+1. Throughput is one block per NR+2 cycles with out_ready tied high.
- Outputs outside ROUND: dp_in=st, dp_final=0, dp_inv=inv. out_data=st only in DONE, 0 otherwise.
- in_valid while not IDLE is ignored. in_data and in_inv are don't-care after accept.
- Reset mid-operation (ROUND or DONE): the block is discarded, state returns to IDLE next cycle, out_valid=0 with no partial result emitted. Reset has priority over all handshakes.
- Index rules: rk_idx is never out of range [0, NR]. The rnd counter never exceeds NR and never wraps.
- Widths: all XOR is 128-bit. No arithmetic beyond the rnd increment and the NR-rnd subtraction, both on IDX_W bits.

Decomposition:
- Shared package holds:
  - sched_state_t enum {IDLE, ROUND, DONE}.
  - AES_BLOCK_W=128.
  - NR constants AES128_NR=10, AES192_NR=12, AES256_NR=14.
- No sub-module is needed in the scheduler itself.
- A top-level aes_iterative_core pairs it with the existing forward/inverse round datapath and the key store.

Test Plan:
- FIPS-197 C.1 encrypt: key 000102...0f, plain 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept. rk_idx sequence 0,1,...,10; dp_final high only when rk_idx=10.
- FIPS-197 C.1 decrypt: in_inv=1, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff. rk_idx sequence 10,9,...,0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0; a block offered meanwhile is not accepted.
- Back-to-back: in_valid and out_ready held high, two encrypts -> accepts 12 cycles apart, both results correct.
- Reset asserted at round 4 -> next cycle FSM=IDLE, in_ready=1, out_valid=0. A following encrypt produces the correct ciphertext.
- NR=14 build with the FIPS-197 C.3 vector: key 000102...1f, plain 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, latency 15 cycles.

Source files
------------

// File: rtl/aes_round_scheduler_pkg.sv
// Shared types and constants for the iterative AES round scheduler.
package aes_round_scheduler_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    localparam int unsigned AES128_NR = 10;
    localparam int unsigned AES192_NR = 12;
    localparam int unsigned AES256_NR = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/aes_round_scheduler.sv
// Iterative AES sequencer: owns the cipher state and drives one external
// round datapath through NR rounds, fetching round keys by index.
module aes_round_scheduler
    import aes_round_scheduler_pkg::*;
#(
    parameter int unsigned NR    = AES128_NR,
    parameter int unsigned IDX_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic [IDX_W-1:0]       rk_idx,
    input  logic [AES_BLOCK_W-1:0] rk_data,
    output logic [AES_BLOCK_W-1:0] dp_in,
    output logic [AES_BLOCK_W-1:0] dp_key,
    output logic                   dp_inv,
    output logic                   dp_final,
    input  logic [AES_BLOCK_W-1:0] dp_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data
);

    localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);

    sched_state_t           state;
    sched_state_t           state_nx;
    logic [AES_BLOCK_W-1:0] st;
    logic [IDX_W-1:0]       rnd;
    logic                   inv;
    logic                   last_rnd;

    assign last_rnd = (rnd == NR_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = ROUND;
            ROUND:   if (last_rnd)  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // rnd saturates at NR on the final round so it never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            st  <= '0;
            rnd <= '0;
            inv <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st  <= in_data ^ rk_data;
                        inv <= in_inv;
                        rnd <= IDX_W'(1);
                    end
                end
                ROUND: begin
                    st <= dp_out;
                    if (!last_rnd) begin
                        rnd <= rnd + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        rnd <= '0;
                    end
                end
                default: begin
                    rnd <= '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        dp_in     = st;
        dp_key    = rk_data;
        dp_inv    = inv;
        dp_final  = 1'b0;
        rk_idx    = inv ? (NR_IDX - rnd) : rnd;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = in_inv ? NR_IDX : '0;
            end
            ROUND: begin
                dp_final = last_rnd;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = st;
            end
            default: begin
                rk_idx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Scoreboard bench for aes_round_scheduler: AES-128 and AES-256 instances,
// each with a behavioural round datapath and expanded-key store.
module tb_aes_round_scheduler;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clock = 1'b0;
    logic         rst       [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         in_inv    [2];
    logic [127:0] in_data   [2];
    logic [3:0]   rk_idx    [2];
    logic [127:0] rk_data   [2];
    logic [127:0] dp_in     [2];
    logic [127:0] dp_key    [2];
    logic         dp_inv    [2];
    logic         dp_final  [2];
    logic [127:0] dp_out    [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_data  [2];

    logic [127:0] rks0 [0:15];
    logic [127:0] rks1 [0:15];
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];

    int           rdy_mode [2];
    int           k        [2];
    logic         kinv     [2];
    logic [127:0] held     [2];
    logic         held_v   [2];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- AES arithmetic (byte 0 = bits 127:120, column-major) ----
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        int         e;
        r    = 8'h01;
        base = a;
        e    = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e    = e / 2;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? isb(s[127-8*i -: 8]) : sb(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int           src;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                src = inv ? (w + 4 * ((c + 4 - w) % 4)) : (w + 4 * ((c + w) % 4));
                r[127-8*(w+4*c) -: 8] = s[127-8*src -: 8];
            end
        return r;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127-8*(4*c+i) -: 8];
            for (int i = 0; i < 4; i++) begin
                if (inv)
                    r[127-8*(4*c+i) -: 8] = gmul(8'h0e, a[i]) ^ gmul(8'h0b, a[(i+1)%4]) ^
                                             gmul(8'h0d, a[(i+2)%4]) ^ gmul(8'h09, a[(i+3)%4]);
                else
                    r[127-8*(4*c+i) -: 8] = gmul(8'h02, a[i]) ^ gmul(8'h03, a[(i+1)%4]) ^
                                             a[(i+2)%4] ^ a[(i+3)%4];
            end
        end
        return r;
    endfunction

    // External round datapath: forward or inverse round, optional final variant.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] key,
                                               input logic inv, input logic fin);
        logic [127:0] t;
        if (!inv) begin
            t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (!fin) t = mix(t, 1'b0);
            return t ^ key;
        end
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ key;
        if (!fin) t = mix(t, 1'b1);
        return t;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    task automatic load_key(input int u, input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = (u == 1) ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            if (u == 1) rks1[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else        rks0[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] rk(input int u, input int r);
        return (u == 1) ? rks1[r] : rks0[r];
    endfunction

    // Reference: the textbook AES cipher and inverse cipher over the key schedule.
    function automatic logic [127:0] model(input int u, input logic [127:0] x, input logic inv);
        logic [127:0] s;
        int           n;
        n = (u == 1) ? 14 : 10;
        if (!inv) begin
            s = x ^ rk(u, 0);
            for (int r = 1; r <= n; r++) begin
                s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
                if (r < n) s = mix(s, 1'b0);
                s = s ^ rk(u, r);
            end
        end else begin
            s = x ^ rk(u, n);
            for (int r = n - 1; r >= 0; r--) begin
                s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk(u, r);
                if (r > 0) s = mix(s, 1'b1);
            end
        end
        return s;
    endfunction

    // ---------------- DUTs and environment ----------------
    aes_round_scheduler #(.NR(10), .IDX_W(4)) u_aes128 (
        .clock(clock), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_inv(in_inv[0]), .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
        .dp_in(dp_in[0]), .dp_key(dp_key[0]), .dp_inv(dp_inv[0]), .dp_final(dp_final[0]),
        .dp_out(dp_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0])
    );

    aes_round_scheduler #(.NR(14), .IDX_W(4)) u_aes256 (
        .clock(clock), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_inv(in_inv[1]), .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
        .dp_in(dp_in[1]), .dp_key(dp_key[1]), .dp_inv(dp_inv[1]), .dp_final(dp_final[1]),
        .dp_out(dp_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1])
    );

    assign rk_data[0] = rks0[rk_idx[0]];
    assign rk_data[1] = rks1[rk_idx[1]];
    assign dp_out[0]  = aes_round(dp_in[0], dp_key[0], dp_inv[0], dp_final[0]);
    assign dp_out[1]  = aes_round(dp_in[1], dp_key[1], dp_inv[1], dp_final[1]);

    always @(negedge clock) begin
        for (int u = 0; u < 2; u++)
            out_ready[u] = (rdy_mode[u] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[u] != 0);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input int u, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got %h expected %h (cycle %0d)", u, name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 1) ? q1.size() : q0.size();
    endfunction

    task automatic qpush(input int u, input logic [127:0] v);
        if (u == 1) q1.push_back(v);
        else        q0.push_back(v);
    endtask

    function automatic logic [127:0] qpop(input int u);
        if (u == 1) return q1.pop_front();
        return q0.pop_front();
    endfunction

    task automatic qclear(input int u);
        if (u == 1) q1.delete();
        else        q0.delete();
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int u);
        int           n;
        logic [127:0] e;
        n = (u == 1) ? 14 : 10;
        if (rst[u]) begin
            k[u]      = 0;
            held_v[u] = 1'b0;
            qclear(u);
            return;
        end
        if (k[u] >= 1 && k[u] <= n) begin
            chk(u, "rk_idx_round", rk_idx[u], kinv[u] ? (n - k[u]) : k[u]);
            chk(u, "dp_final", dp_final[u], k[u] == n);
            chk(u, "dp_inv", dp_inv[u], kinv[u]);
            chk(u, "busy_in_ready", in_ready[u], 0);
            k[u]++;
        end else if (k[u] == n + 1) begin
            chk(u, "latency_out_valid", out_valid[u], 1);
            k[u] = 0;
        end
        if (in_valid[u] && in_ready[u]) begin
            chk(u, "rk_idx_accept", rk_idx[u], in_inv[u] ? n : 0);
            k[u]    = 1;
            kinv[u] = in_inv[u];
        end
        if (out_valid[u]) begin
            if (held_v[u]) chk(u, "hold_stable", out_data[u], held[u]);
            held[u]   = out_data[u];
            held_v[u] = 1'b1;
            if (out_ready[u]) begin
                held_v[u] = 1'b0;
                if (qsize(u) == 0) begin
                    chk(u, "unexpected_output", 1, 0);
                end else begin
                    e = qpop(u);
                    chk(u, "out_data", out_data[u], e);
                end
            end
        end else begin
            held_v[u] = 1'b0;
            chk(u, "out_data_idle_zero", out_data[u], 0);
        end
    endtask

    always @(negedge clock) begin
        #1;
        mon(0);
        mon(1);
    end

    // ---------------- stimulus ----------------
    task automatic send(input int u, input logic inv, input logic [127:0] d, input logic [127:0] exp,
                        input bit hold, output int acc);
        int n;
        @(negedge clock);
        in_valid[u] = 1'b1;
        in_inv[u]   = inv;
        in_data[u]  = d;
        n = 0;
        #1;
        while (!in_ready[u] && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready[u]) begin
            chk(u, "accept_timeout", 0, 1);
            in_valid[u] = 1'b0;
            acc = -1;
            return;
        end
        qpush(u, exp);
        acc = cyc;
        @(posedge clock);
        #1;
        if (!hold) in_valid[u] = 1'b0;
    endtask

    task automatic wait_drain(input int u);
        int n;
        n = 0;
        @(negedge clock);
        #2;
        while ((qsize(u) != 0 || !in_ready[u]) && n < 300) begin
            @(negedge clock);
            #2;
            n++;
        end
        if (qsize(u) != 0 || !in_ready[u]) chk(u, "drain_timeout", 0, 1);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc1;
        int           acc2;
        int           n;
        logic         inv;
        logic [127:0] p;
        logic [127:0] c;

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; in_valid[u] = 1'b0; in_inv[u] = 1'b0; in_data[u] = '0;
            rdy_mode[u] = 1; k[u] = 0; kinv[u] = 1'b0; held[u] = '0; held_v[u] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            rks0[i] = '0;
            rks1[i] = '0;
        end
        load_key(0, {K128, 128'h0}, 4);
        load_key(1, K256, 8);

        repeat (3) @(negedge clock);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #2;
        for (int u = 0; u < 2; u++) begin
            chk(u, "reset_in_ready", in_ready[u], 1);
            chk(u, "reset_out_valid", out_valid[u], 0);
            chk(u, "reset_out_data", out_data[u], 0);
            chk(u, "reset_dp_final", dp_final[u], 0);
            chk(u, "reset_dp_inv", dp_inv[u], 0);
            chk(u, "reset_rk_idx", rk_idx[u], 0);
        end

        // Known-answer encrypt and decrypt, AES-128.
        send(0, 1'b0, PT, C128, 1'b0, acc1);
        wait_drain(0);
        send(0, 1'b1, C128, PT, 1'b0, acc1);
        wait_drain(0);

        // Backpressure in DONE; a block offered meanwhile must be ignored.
        rdy_mode[0] = 0;
        @(negedge clock);
        send(0, 1'b0, PT, C128, 1'b0, acc1);
        n = 0;
        @(negedge clock);
        #2;
        while (!out_valid[0] && n < 40) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk(0, "bp_reach_done", out_valid[0], 1);
        repeat (5) begin
            @(negedge clock);
            in_valid[0] = 1'b1;
            in_inv[0]   = 1'b0;
            in_data[0]  = ~PT;
            #2;
            chk(0, "bp_in_ready_low", in_ready[0], 0);
            chk(0, "bp_out_valid_held", out_valid[0], 1);
            chk(0, "bp_out_data_held", out_data[0], C128);
        end
        @(negedge clock);
        in_valid[0] = 1'b0;
        rdy_mode[0] = 1;
        wait_drain(0);

        // Back-to-back with in_valid and out_ready held high.
        send(0, 1'b0, PT, C128, 1'b1, acc1);
        send(0, 1'b0, PT ^ 128'h1, model(0, PT ^ 128'h1, 1'b0), 1'b0, acc2);
        chk(0, "b2b_accept_spacing", acc2 - acc1, 12);
        wait_drain(0);

        // Reset during round 4 discards the block.
        send(0, 1'b0, PT, C128, 1'b0, acc1);
        repeat (4) @(negedge clock);
        rst[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        #2;
        chk(0, "midreset_in_ready", in_ready[0], 1);
        chk(0, "midreset_out_valid", out_valid[0], 0);
        send(0, 1'b0, PT, C128, 1'b0, acc1);
        wait_drain(0);

        // Randomized keys, blocks, directions and output backpressure; each
        // block is followed by its round-trip.
        for (int b = 0; b < 14; b++) begin
            wait_drain(0);
            rdy_mode[0] = 1;
            load_key(0, {rand128(), 128'h0}, 4);
            rdy_mode[0] = 2;
            p   = rand128();
            inv = 1'($urandom_range(0, 1));
            c   = model(0, p, inv);
            send(0, inv, p, c, 1'($urandom_range(0, 1)), acc1);
            send(0, ~inv, c, p, 1'b0, acc1);
        end
        wait_drain(0);
        rdy_mode[0] = 1;

        // AES-256 instance: known answer, inverse, and random round-trips.
        send(1, 1'b0, PT, C256, 1'b0, acc1);
        wait_drain(1);
        send(1, 1'b1, C256, PT, 1'b0, acc1);
        wait_drain(1);
        for (int b = 0; b < 4; b++) begin
            wait_drain(1);
            rdy_mode[1] = 1;
            load_key(1, {rand128(), rand128()}, 8);
            rdy_mode[1] = 2;
            p = rand128();
            c = model(1, p, 1'b0);
            send(1, 1'b0, p, c, 1'b1, acc1);
            send(1, 1'b1, c, p, 1'b0, acc1);
        end
        wait_drain(1);

        chk(0, "final_queue_empty", qsize(0), 0);
        chk(1, "final_queue_empty", qsize(1), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
